// File: rtl/self_test_pkg.sv
// Shared definitions for the multi-layer self-test block.
//   HDR_DEFAULT : header value a test word must carry to be accepted
//   *_OFS       : distance of each 4-bit field from the word MSB
//   FIELD_W     : width of the header / flags / key / id fields
//   state_t     : controller states (COLLECT, WAIT_TX, TX, DONE)
package self_test_pkg;

    localparam logic [3:0] HDR_DEFAULT = 4'b1010;

    localparam int FIELD_W   = 4;
    localparam int HDR_OFS   = 0;
    localparam int FLAGS_OFS = 4;   // flags are carried but never interpreted
    localparam int KEY_OFS   = 8;
    localparam int ID_OFS    = 12;  // layer id travels with the word untouched

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT_TX = 2'd1,
        TX      = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/st_uart_tx.sv
// UART-style frame serialiser.
// A frame is: start bit 0, DATA_W data bits LSB first, stop bit 1; every bit
// lasts CLK_DIV clock cycles. A load pulse in the cycle frame_done is high
// starts the next frame with no idle gap between the stop and start bits.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : start a frame with word (also accepted while busy)
//   word        : data to serialise, captured on load
//   tx_out      : serial line, idles high
//   frame_done  : high during the final cycle of the stop bit
module st_uart_tx #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    output logic              tx_out,
    output logic              frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // bit_cnt 0 = start bit, 1..DATA_W = data bits, DATA_W+1 = stop bit
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W + 1);

    logic              busy;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    // Remaining data bits with the stop bit parked above them; shifting in
    // ones keeps the line high once the data has drained.
    logic [DATA_W:0]   shreg;
    logic              bit_end;

    assign bit_end    = busy && (div_cnt == DIV_LAST);
    assign frame_done = bit_end && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
            tx_out  <= 1'b1;
        end else if (load) begin
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= {1'b1, word};
            tx_out  <= 1'b0;
        end else if (frame_done) begin
            busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_out  <= 1'b1;
        end else if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            tx_out  <= shreg[0];
            shreg   <= {1'b1, shreg[DATA_W:1]};
        end else if (busy) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/self_test_multi.sv
// Multi-layer self-test collector and serialiser.
// Collects LAYERS test words with a valid header, keeping them sorted by key
// (stable insertion, done at the accepting edge). On the bottom layer
// (f_layer=1) the sorted set is sent back-to-back through st_uart_tx.
// Handshake: a word transfers on a rising edge where data_valid and
// data_ready are both high; data_ready is high only in COLLECT and never
// depends on data_valid; the producer holds data_in stable while valid.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   f_layer      : bottom-layer flag, sampled only while waiting to transmit
//   data_in      : test word {header, flags, key, id, payload}
//   data_valid   : data_in valid this cycle
//   data_ready   : block accepts a word this cycle
//   tx_out       : serial output, idles high
//   sort_finish  : all words captured and sorted
//   tx_busy      : serial frame sequence in progress
//   data_out     : word of the current (or last) frame
//   err_cnt      : rejected-header count, saturating at 255
//   fsm_state    : current controller state (state_t encoding)
module self_test_multi
    import self_test_pkg::*;
#(
    parameter int         DATA_W  = 32,
    parameter int         LAYERS  = 4,
    parameter int         CLK_DIV = 8,
    parameter logic [3:0] HDR     = HDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_layer,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              sort_finish,
    output logic              tx_busy,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        err_cnt,
    output logic [1:0]        fsm_state
);

    localparam int CNT_W  = $clog2(LAYERS + 1);
    localparam int HDR_HI = DATA_W - 1 - HDR_OFS;
    localparam int KEY_HI = DATA_W - 1 - KEY_OFS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAYERS - 1);
    localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(LAYERS);

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] sort_buf [LAYERS];
    logic [DATA_W-1:0] buf_ins  [LAYERS];
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  ins_pos;
    logic [CNT_W-1:0]  tx_idx;     // index of the next word to frame

    logic              accept;
    logic              hdr_ok;
    logic              word_ok;
    logic              word_bad;
    logic [FIELD_W-1:0] new_key;

    logic              uart_load;
    logic [DATA_W-1:0] load_word;
    logic              frame_done;

    assign accept   = data_valid & data_ready;
    assign hdr_ok   = (data_in[HDR_HI -: FIELD_W] == HDR);
    assign word_ok  = accept & hdr_ok;
    assign word_bad = accept & ~hdr_ok;
    assign new_key  = data_in[KEY_HI -: FIELD_W];
    assign fsm_state = state;

    // The buffer is kept sorted, so stored keys <= new_key form a prefix;
    // counting them gives the slot right after the last equal key (stable).
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if ((CNT_W'(i) < count) && (sort_buf[i][KEY_HI -: FIELD_W] <= new_key))
                ins_pos = ins_pos + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < LAYERS; i++) begin
            buf_ins[i] = sort_buf[i];
            if (CNT_W'(i) == ins_pos)
                buf_ins[i] = data_in;
            else if (CNT_W'(i) > ins_pos)
                buf_ins[i] = sort_buf[(i == 0) ? 0 : i - 1];
        end
    end

    // Frame launch: first word when leaving WAIT_TX, then each following
    // word in the cycle the previous stop bit ends.
    always_comb begin
        uart_load = 1'b0;
        load_word = sort_buf[0];
        if (state == WAIT_TX && f_layer) begin
            uart_load = 1'b1;
            load_word = sort_buf[0];
        end else if (state == TX && frame_done && tx_idx != ALL_CNT) begin
            uart_load = 1'b1;
            load_word = sort_buf[tx_idx];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (word_ok && count == LAST_CNT) state_next = WAIT_TX;
            WAIT_TX: if (f_layer)                      state_next = TX;
            TX:      if (frame_done && tx_idx == ALL_CNT) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_next;
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state, and data_ready stays low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_ready  <= 1'b0;
            sort_finish <= 1'b0;
            tx_busy     <= 1'b0;
        end else begin
            data_ready  <= (state_next == COLLECT);
            sort_finish <= (state_next != COLLECT);
            tx_busy     <= (state_next == TX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAYERS; i++) sort_buf[i] <= '0;
            count    <= '0;
            err_cnt  <= '0;
            tx_idx   <= '0;
            data_out <= '0;
        end else begin
            if (word_ok) begin
                sort_buf <= buf_ins;
                count    <= count + 1'b1;
            end
            if (word_bad && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (uart_load) begin
                data_out <= load_word;
                tx_idx   <= (state == WAIT_TX) ? CNT_W'(1) : tx_idx + 1'b1;
            end
        end
    end

    st_uart_tx #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (uart_load),
        .word       (load_word),
        .tx_out     (tx_out),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_self_test_multi.sv
module tb_self_test_multi;

    localparam int DATA_W  = 32;
    localparam int LAYERS  = 3;
    localparam int CLK_DIV = 8;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_WAIT_TX = 2'd1;
    localparam logic [1:0] S_TX      = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              f_layer = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic              tx_out;
    logic              sort_finish;
    logic              tx_busy;
    logic [DATA_W-1:0] data_out;
    logic [7:0]        err_cnt;
    logic [1:0]        fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    self_test_multi #(
        .DATA_W  (DATA_W),
        .LAYERS  (LAYERS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_layer     (f_layer),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .tx_out      (tx_out),
        .sort_finish (sort_finish),
        .tx_busy     (tx_busy),
        .data_out    (data_out),
        .err_cnt     (err_cnt),
        .fsm_state   (fsm_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, " rst tx_out"},      tx_out, 1);
        check_eq({tag, " rst sort_finish"}, sort_finish, 0);
        check_eq({tag, " rst tx_busy"},     tx_busy, 0);
        check_eq({tag, " rst data_ready"},  data_ready, 0);
        check_eq({tag, " rst data_out"},    data_out, 0);
        check_eq({tag, " rst err_cnt"},     err_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, " post-rst data_ready"}, data_ready, 1);
        check_eq({tag, " post-rst state"},      fsm_state, S_COLLECT);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        data_in    = w;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data_in    = '0;
    endtask

    // Called at the first cycle of a frame; samples each bit mid-period.
    task automatic capture_frame(input string tag, input logic [DATA_W-1:0] exp);
        logic [DATA_W+1:0] rx;
        rx = '0;
        check_eq({tag, " data_out"}, data_out, exp);
        for (int b = 0; b < DATA_W + 2; b++) begin
            repeat (CLK_DIV / 2) @(posedge clk);
            #1;
            rx[b] = tx_out;
            if (b == DATA_W + 1) begin
                repeat (CLK_DIV / 2 - 1) @(posedge clk);
                #1;
                check_eq({tag, " busy at frame end"}, tx_busy, 1);
                @(posedge clk);
                #1;
            end else begin
                repeat (CLK_DIV - CLK_DIV / 2) @(posedge clk);
                #1;
            end
        end
        check_eq({tag, " start bit"}, rx[0], 0);
        check_eq({tag, " data bits"}, rx[DATA_W:1], exp);
        check_eq({tag, " stop bit"},  rx[DATA_W+1], 1);
    endtask

    task automatic check_done(input string tag);
        check_eq({tag, " done tx_busy"},     tx_busy, 0);
        check_eq({tag, " done tx_out"},      tx_out, 1);
        check_eq({tag, " done sort_finish"}, sort_finish, 1);
        check_eq({tag, " done state"},       fsm_state, S_DONE);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // ---- reset, then idle with no valid
        do_reset("t0");
        repeat (20) @(posedge clk);
        #1;
        check_eq("idle tx_out",      tx_out, 1);
        check_eq("idle data_ready",  data_ready, 1);
        check_eq("idle sort_finish", sort_finish, 0);
        check_eq("idle err_cnt",     err_cnt, 0);

        // ---- sort keys 2,0,1 and transmit
        f_layer = 1'b1;
        send_word(32'h5201BEAF);
        check_eq("bad hdr err_cnt", err_cnt, 1);
        check_eq("bad hdr state",   fsm_state, S_COLLECT);
        send_word(32'hA0211234);
        send_word(32'hA0025678);
        check_eq("2 words sort_finish", sort_finish, 0);
        check_eq("2 words data_ready",  data_ready, 1);
        send_word(32'hA0139ABC);
        check_eq("3rd accept sort_finish", sort_finish, 1);
        check_eq("3rd accept data_ready",  data_ready, 0);
        check_eq("3rd accept state",       fsm_state, S_WAIT_TX);
        check_eq("3rd accept tx_out",      tx_out, 1);
        @(posedge clk);
        #1;
        check_eq("tx start state",   fsm_state, S_TX);
        check_eq("tx start tx_busy", tx_busy, 1);
        f_layer = 1'b0;  // must not abort transmission
        capture_frame("t1 f0", 32'hA0025678);
        capture_frame("t1 f1", 32'hA0139ABC);
        capture_frame("t1 f2", 32'hA0211234);
        check_done("t1");

        // ---- err_cnt saturation, stability, f_layer held low
        do_reset("t2");
        f_layer = 1'b0;
        for (int i = 0; i < 256; i++) send_word({4'h5, 28'(i)});
        check_eq("sat err_cnt",    err_cnt, 255);
        check_eq("sat state",      fsm_state, S_COLLECT);
        send_word(32'hA0311111);
        check_eq("sat err_cnt hold", err_cnt, 255);
        send_word(32'hA0155555);
        send_word(32'hA0322222);
        repeat (20) @(posedge clk);
        #1;
        check_eq("hold state",       fsm_state, S_WAIT_TX);
        check_eq("hold tx_out",      tx_out, 1);
        check_eq("hold sort_finish", sort_finish, 1);
        check_eq("hold tx_busy",     tx_busy, 0);
        f_layer = 1'b1;
        @(posedge clk);
        #1;
        check_eq("raise f_layer start bit", tx_out, 0);
        capture_frame("t2 f0", 32'hA0155555);
        capture_frame("t2 f1", 32'hA0311111);
        capture_frame("t2 f2", 32'hA0322222);
        check_done("t2");

        // ---- reset in the middle of word 1, data bit 10
        do_reset("t3");
        f_layer = 1'b1;
        send_word(32'hA0200000);
        send_word(32'hA0000000);
        send_word(32'hA0100000);
        @(posedge clk);
        #1;
        capture_frame("t3 f0", 32'hA0000000);
        repeat (11 * CLK_DIV + CLK_DIV / 2) @(posedge clk);
        #1;
        check_eq("mid-frame bit10", tx_out, 0);
        check_eq("mid-frame data_out", data_out, 32'hA0100000);
        rst_n = 1'b0;
        #1;
        check_eq("async rst tx_out",      tx_out, 1);
        check_eq("async rst sort_finish", sort_finish, 0);
        check_eq("async rst data_out",    data_out, 0);
        check_eq("async rst tx_busy",     tx_busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("re-collect state",      fsm_state, S_COLLECT);
        check_eq("re-collect data_ready", data_ready, 1);
        send_word(32'hA0700000);
        send_word(32'hA0600000);
        check_eq("empty buf 2 words state", fsm_state, S_COLLECT);
        check_eq("empty buf sort_finish",   sort_finish, 0);
        send_word(32'hA0500000);
        check_eq("empty buf 3 words state", fsm_state, S_WAIT_TX);
        @(posedge clk);
        #1;
        capture_frame("t3 new f0", 32'hA0500000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
